// File: rtl/dsp_rectifier_pkg.sv
// Shared rectifier types and the width-generic rectify function.
// One function serves the datapath and any reference model, so both agree on saturation.
package dsp_rectifier_pkg;

  localparam int unsigned RECT_W = 32;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FULL   = 2'd1,
    HALF   = 2'd2,
    RSVD   = 2'd3
  } rect_mode_e;

  // data is sign-extended to RECT_W and w is the real sample width; returns {sat, result}
  function automatic logic [RECT_W:0] rect_f(input logic signed [RECT_W-1:0] data,
                                             input int unsigned w,
                                             input rect_mode_e mode);
    logic signed [RECT_W-1:0] max_pos;
    logic signed [RECT_W-1:0] res;
    logic sat;
    max_pos = signed'((RECT_W'(1) << (w - 1)) - RECT_W'(1));
    sat = 1'b0;
    res = data;
    case (mode)
      BYPASS: res = data;
      HALF: if (data < 0) res = '0;
      default: begin
        if (data < -max_pos) begin
          res = max_pos;
          sat = 1'b1;
        end else if (data < 0) begin
          res = -data;
        end
      end
    endcase
    return {sat, res};
  endfunction

endpackage

// File: rtl/dsp_peak_tracker.sv
// Per-channel peak-hold of rectified magnitudes with clear and registered readback.
module dsp_peak_tracker
  import dsp_rectifier_pkg::*;
#(
  parameter int unsigned CH     = 4,
  parameter int unsigned DATA_W = 12,
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_upd,
  input  logic [CH_W-1:0]   i_upd_chan,
  input  logic [DATA_W-1:0] i_upd_val,
  input  logic              i_clr,
  input  logic [CH_W-1:0]   i_sel,
  output logic [DATA_W-1:0] o_peak
);

  logic [DATA_W-1:0] peak_q [CH];
  logic [DATA_W-1:0] peak_d [CH];
  logic [DATA_W-1:0] rd_val;

  // Clear applies before the update so a same-cycle clear+update leaves the new result
  always_comb begin
    rd_val = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      peak_d[c] = peak_q[c];
      if (i_clr && (32'(i_sel) == c)) peak_d[c] = '0;
      if (i_upd && (32'(i_upd_chan) == c) && (i_upd_val > peak_d[c])) peak_d[c] = i_upd_val;
      if (32'(i_sel) == c) rd_val = peak_q[c];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned c = 0; c < CH; c++) peak_q[c] <= '0;
      o_peak <= '0;
    end else begin
      peak_q <= peak_d;
      o_peak <= rd_val;
    end
  end

endmodule

// File: rtl/dsp_rectifier_mc.sv
// Multi-channel rectifier: 2-stage stall-all pipeline with per-channel peak hold.
module dsp_rectifier_mc
  import dsp_rectifier_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CH     = 4,
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CH_W-1:0]   i_chan,
  input  logic [1:0]        i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_chan,
  output logic              o_sat,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_peak_clr,
  input  logic [CH_W-1:0]   i_peak_sel,
  output logic [DATA_W-1:0] o_peak
);

  logic                     en;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_data;
  logic [CH_W-1:0]          s1_chan;
  rect_mode_e               s1_mode;
  logic [RECT_W:0]          rect_full;
  logic [DATA_W-1:0]        rect_res;
  logic                     rect_sat;
  logic                     rect_unused;
  logic                     upd;

  // Whole pipe advances together; o_ready is a combinational path from i_ready
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // Out-of-range channels are consumed here and become bubbles
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_chan  <= '0;
      s1_mode  <= BYPASS;
    end else if (en) begin
      s1_valid <= i_valid && (32'(i_chan) < CH);
      s1_data  <= i_data;
      s1_chan  <= i_chan;
      s1_mode  <= rect_mode_e'(i_mode);
    end
  end

  assign rect_full   = rect_f(RECT_W'(s1_data), DATA_W, s1_mode);
  assign rect_res    = rect_full[DATA_W-1:0];
  assign rect_sat    = rect_full[RECT_W];
  assign rect_unused = ^rect_full[RECT_W-1:DATA_W];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      o_sat   <= 1'b0;
    end else if (en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data <= rect_res;
        o_chan <= s1_chan;
        o_sat  <= rect_sat;
      end
    end
  end

  assign upd = en && s1_valid && (s1_mode != BYPASS);

  dsp_peak_tracker #(
    .CH     (CH),
    .DATA_W (DATA_W)
  ) u_peak (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_upd      (upd),
    .i_upd_chan (s1_chan),
    .i_upd_val  (rect_res),
    .i_clr      (i_peak_clr),
    .i_sel      (i_peak_sel),
    .o_peak     (o_peak)
  );

endmodule

// File: tb/tb_dsp_rectifier_mc.sv
// Scoreboard bench for dsp_rectifier_mc: CH=4 main instance plus a CH=3 instance for tag drops.
module tb_dsp_rectifier_mc;
  import dsp_rectifier_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [11:0] i_data;
  logic [1:0]  i_chan;
  logic [1:0]  i_mode;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_data;
  logic [1:0]  o_chan;
  logic        o_sat;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        i_peak_clr;
  logic [1:0]  i_peak_sel;
  logic [11:0] o_peak;

  logic [11:0] i_data3;
  logic [1:0]  i_chan3;
  logic [1:0]  i_mode3;
  logic        i_valid3;
  logic        o_ready3;
  logic [11:0] o_data3;
  logic [1:0]  o_chan3;
  logic        o_sat3;
  logic        o_valid3;
  logic        i_ready3 = 1'b1;
  logic        i_peak_clr3;
  logic [1:0]  i_peak_sel3;
  logic [11:0] o_peak3;

  dsp_rectifier_mc #(.DATA_W(12), .CH(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(i_data), .i_chan(i_chan), .i_mode(i_mode),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_chan(o_chan), .o_sat(o_sat),
    .o_valid(o_valid), .i_ready(i_ready), .i_peak_clr(i_peak_clr), .i_peak_sel(i_peak_sel),
    .o_peak(o_peak)
  );

  dsp_rectifier_mc #(.DATA_W(12), .CH(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_data(i_data3), .i_chan(i_chan3), .i_mode(i_mode3),
    .i_valid(i_valid3), .o_ready(o_ready3), .o_data(o_data3), .o_chan(o_chan3), .o_sat(o_sat3),
    .o_valid(o_valid3), .i_ready(i_ready3), .i_peak_clr(i_peak_clr3), .i_peak_sel(i_peak_sel3),
    .o_peak(o_peak3)
  );

  typedef struct {
    logic [11:0] d;
    logic [1:0]  c;
    logic        s;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        q3[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          valid3_cnt = 0;
  bit          chk_lat = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [11:0] pk_model [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares the presented beat against the queue head every cycle it is shown
  always @(negedge clk) begin
    if (rstn && o_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data 0x%0h chan %0d expected no beat", o_data, o_chan);
      end else begin
        chk("o_data", 32'(o_data), 32'(q[0].d));
        chk("o_chan", 32'(o_chan), 32'(q[0].c));
        chk("o_sat", 32'(o_sat), 32'(q[0].s));
        if (chk_lat) chk("latency", 32'(cyc - q[0].cyc), 32'd2);
        if (i_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && o_valid3) begin
      valid3_cnt++;
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat3: got data 0x%0h chan %0d expected no beat", o_data3, o_chan3);
      end else begin
        chk("o_data3", 32'(o_data3), 32'(q3[0].d));
        chk("o_chan3", 32'(o_chan3), 32'(q3[0].c));
        chk("o_sat3", 32'(o_sat3), 32'(q3[0].s));
        void'(q3.pop_front());
      end
    end
  end

  task automatic send(input logic [11:0] d, input logic [1:0] ch, input rect_mode_e m,
                      input logic [11:0] ed, input logic es);
    exp_t e;
    int   n;
    bit   acc;
    n = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_chan  = ch;
    i_mode  = m;
    while (!acc) begin
      @(negedge clk);
      acc = o_ready;
      if (acc) begin
        e.d = ed; e.c = ch; e.s = es; e.cyc = cyc;
        q.push_back(e);
        if (m != BYPASS && ed > pk_model[ch]) pk_model[ch] = ed;
      end
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 500) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send3(input logic [11:0] d, input logic [1:0] ch, input rect_mode_e m,
                       input bit expect_out, input logic [11:0] ed, input logic es);
    exp_t e;
    i_valid3 = 1'b1;
    i_data3  = d;
    i_chan3  = ch;
    i_mode3  = m;
    @(negedge clk);
    chk("o_ready3", 32'(o_ready3), 32'd1);
    if (expect_out) begin
      e.d = ed; e.c = ch; e.s = es; e.cyc = cyc;
      q3.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid3 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q3.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q.size() + q3.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_peak(input logic [1:0] s, input logic [11:0] e, input string nm);
    i_peak_sel = s;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(nm, 32'(o_peak), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_peak3(input logic [1:0] s, input logic [11:0] e, input string nm);
    i_peak_sel3 = s;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(nm, 32'(o_peak3), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_chan", 32'(o_chan), 32'd0);
    chk("rst_o_sat", 32'(o_sat), 32'd0);
    chk("rst_o_peak", 32'(o_peak), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd1);
    chk("rst_o_ready3", 32'(o_ready3), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r;
    logic [11:0] d;
    logic [1:0]  ch;
    rect_mode_e  m;

    rstn = 1'b0;
    i_data = '0; i_chan = '0; i_mode = '0; i_valid = 1'b0; i_peak_clr = 1'b0; i_peak_sel = '0;
    i_data3 = '0; i_chan3 = '0; i_mode3 = '0; i_valid3 = 1'b0; i_peak_clr3 = 1'b0; i_peak_sel3 = '0;
    for (int i = 0; i < 4; i++) pk_model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // FULL sweep then HALF/BYPASS, back to back with latency check
    chk_lat = 1'b1;
    send(12'hFFB, 2'd0, FULL, 12'h005, 1'b0);
    send(12'h7FF, 2'd0, FULL, 12'h7FF, 1'b0);
    send(12'h800, 2'd0, FULL, 12'h7FF, 1'b1);
    send(12'h000, 2'd0, FULL, 12'h000, 1'b0);
    send(12'hFFB, 2'd0, HALF, 12'h000, 1'b0);
    send(12'h007, 2'd0, HALF, 12'h007, 1'b0);
    send(12'h800, 2'd0, RSVD, 12'h7FF, 1'b1);
    send(12'h800, 2'd1, BYPASS, 12'h800, 1'b0);
    drain();
    chk_peak(2'd0, 12'h7FF, "peak_ch0");
    chk_peak(2'd1, 12'h000, "peak_ch1_bypass");

    // Peak tracking on ch2
    send(12'hF00, 2'd2, FULL, 12'h100, 1'b0);
    send(12'h050, 2'd2, FULL, 12'h050, 1'b0);
    send(12'hE00, 2'd2, FULL, 12'h200, 1'b0);
    drain();
    chk_peak(2'd2, 12'h200, "peak_ch2");
    chk_peak(2'd3, 12'h000, "peak_ch3");

    // Clear lands in the same cycle the 0x010 beat loads into S2
    send(12'h010, 2'd2, FULL, 12'h010, 1'b0);
    i_peak_clr = 1'b1;
    i_peak_sel = 2'd2;
    @(posedge clk);
    #1;
    i_peak_clr = 1'b0;
    pk_model[2] = 12'h010;
    drain();
    chk_peak(2'd2, 12'h010, "peak_ch2_clr_upd");
    chk_peak(2'd1, 12'h000, "peak_ch1_after_clr");
    chk_lat = 1'b0;

    // Random stream under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 420; i++) begin
      d  = 12'($urandom);
      ch = 2'($urandom_range(0, 3));
      m  = rect_mode_e'($urandom_range(0, 3));
      r  = rect_f(32'(signed'(d)), 12, m);
      send(d, ch, m, r[11:0], r[32]);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    drain();
    for (int c = 0; c < 4; c++) chk_peak(2'(c), pk_model[c], "peak_random");

    // Reset with two beats in flight
    send(12'h900, 2'd1, FULL, 12'h700, 1'b0);
    send(12'h901, 2'd3, FULL, 12'h6FF, 1'b0);
    rstn = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) pk_model[i] = '0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) chk_peak(2'(c), 12'h000, "peak_after_reset");

    // CH=3 instance: tag 3 is consumed silently
    send3(12'h800, 2'd3, FULL, 1'b0, 12'h000, 1'b0);
    send3(12'h100, 2'd3, HALF, 1'b0, 12'h000, 1'b0);
    send3(12'hF00, 2'd3, RSVD, 1'b0, 12'h000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("oob_no_valid", 32'(valid3_cnt), 32'd0);
    for (int c = 0; c < 4; c++) chk_peak3(2'(c), 12'h000, "peak3_oob");
    send3(12'hFFB, 2'd1, FULL, 1'b1, 12'h005, 1'b0);
    drain();
    chk("oob_then_valid", 32'(valid3_cnt), 32'd1);
    chk_peak3(2'd1, 12'h005, "peak3_ch1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_rectifier_mc.md
# dsp_rectifier_mc

Parametrised, multi-channel successor to the single-channel rectifier in the DSP front end. It accepts time-multiplexed signed samples tagged with a channel index and applies a per-beat mode: bypass, full-wave with saturation, or half-wave. Output flows through a 2-stage pipeline with ready/valid backpressure. Per-channel peak-hold registers track the largest rectified magnitude for the AGC/monitor logic downstream.

## Interface
Parameters:
- DATA_W, 12, signed sample width (two's complement, MSB = sign)
- CH, 4, number of channels (≥1)
- CH_W, $clog2(CH) (min 1), channel tag width (derived, not overridden)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - i_clk  in  1  clock
  - i_rstn  in  1  asynchronous active-low reset
- Input stream:
  - i_data  in  DATA_W  signed input sample
  - i_chan  in  CH_W  channel tag of input sample (values ≥ CH: beat is dropped, still handshaken)
  - i_mode  in  2  rectify mode, sampled with each beat
  - i_valid  in  1  input beat valid
  - o_ready  out  1  block can accept a beat this cycle
- Output stream:
  - o_data  out  DATA_W  rectified sample
  - o_chan  out  CH_W  channel tag of o_data
  - o_sat  out  1  beat was saturated (full-wave of most-negative value)
  - o_valid  out  1  output beat valid
  - i_ready  in  1  downstream accepts output beat
- Peak hold:
  - i_peak_clr  in  1  clear peak of channel i_peak_sel
  - i_peak_sel  in  CH_W  peak readback/clear select
  - o_peak  out  DATA_W  registered peak of selected channel

## Operation
- Modes (from dsp_rectifier_pkg::rect_mode_e):
  - 0 BYPASS: o_data = i_data, o_sat = 0
  - 1 FULL: o_data = |i_data|; -2^(DATA_W-1) yields 2^(DATA_W-1)-1 with o_sat = 1
  - 2 HALF: negative samples give 0, non-negative pass unchanged
  - 3 reserved: behaves as FULL
- Pipeline: S1 registers data/chan/mode; S2 computes and registers result, sat and chan. S2 is the output register.
- Stall-all handshake: en = !o_valid | i_ready; o_ready = en (combinational from i_ready, documented path).
  - A beat is accepted when i_valid & o_ready.
  - While en = 0, S1/S2 hold and o_data/o_chan/o_sat are stable.
- Bubbles: S1 valid follows (i_valid & en); empty slots propagate as o_valid = 0.
- Peak update: when a beat loads into S2 with channel < CH and mode ≠ BYPASS, peak[chan] = max(peak[chan], result). Result is treated as unsigned magnitude. BYPASS beats do not update the peak.
- Peak clear: i_peak_clr zeroes peak[i_peak_sel].
  - Clear and update on the same channel in the same cycle: peak = result (clear first, then update).
  - i_peak_sel ≥ CH: clear ignored, o_peak = 0.
- o_peak = peak[i_peak_sel] registered (1 cycle), and reflects updates committed in the prior cycle.
- Out-of-range i_chan: beat is consumed at input, never produces o_valid, and never touches any peak.

## Timing
- Latency: 2 cycles, accept edge to o_valid, with no stall. Throughput: 1 beat/cycle with i_ready held high.
- Reset (async assert, sync deassert handled upstream): o_valid, o_data, o_chan, o_sat, o_peak and all peaks go to 0. o_ready = 1 after reset.
- Reset mid-stream: in-flight beats are discarded with no o_valid and no peak change. The first beat after reset sees peaks = 0.
- Held o_valid with i_ready = 0 for N cycles: exactly one transfer happens when i_ready rises, with no duplication or loss.
- i_mode is per-beat; changing it between beats is legal with no flush.

## Structure
- Package dsp_rectifier_pkg holds:
  - rect_mode_e (BYPASS = 0, FULL = 1, HALF = 2, RSVD = 3)
  - function rect_f(data, mode) returning {sat, result}, shared by RTL and bench model
- Sub-module dsp_peak_tracker (CH, DATA_W) holds the peak array, update/clear logic and the registered readback.
- The top holds the pipeline registers and handshake.

## Test plan
All scenarios use DATA_W = 12, CH = 4.
- FULL sweep: 0xFFB (-5) → 5, 0x7FF → 0x7FF, 0x800 → 0x7FF with o_sat = 1, 0x000 → 0. Each appears 2 cycles after accept, in order.
- HALF/BYPASS: HALF 0xFFB → 0 and 0x007 → 7; BYPASS 0x800 → 0x800 with o_sat = 0 and peak unchanged.
- Backpressure: stream 420 random beats (random modes/channels) with i_ready toggled randomly. The output sequence matches the rect_f queue model exactly: no loss, no duplicates, data stable while stalled.
- Peak: ch2 gets FULL samples 0xF00 (-256), 0x050, 0xE00 (-512), so o_peak(sel = 2) = 512. Clear plus a simultaneous 0x010 update on ch2 gives peak = 16. Other channels stay 0.
- Out-of-range: with CH = 3 (CH_W = 2), i_chan = 3 beats are accepted, produce no o_valid, and leave all peaks unchanged.
- Reset mid-stream: assert i_rstn = 0 with 2 beats in flight. All outputs and peaks read 0, neither beat emerges, and o_ready = 1 after release.
